// File: rtl/zmips_pkg.sv
// Shared definitions for the zmips MEM stage: bus FSM states, default
// timeout and the hard-wired zero register number.
package zmips_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } busState_t;

   localparam int TIMEOUT_DEF = 16;
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Word accesses only: any low address bit set is a misaligned access.
   function automatic logic isMisaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/zmips_dbus_if.sv
// Data-bus bundle between the zmips MEM stage (master) and memory (slave).
interface zmips_dbus_if;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_wdata_oe;
   logic        d_rd;
   logic        d_wr;
   logic [31:0] d_rdata;
   logic        d_ack;

   modport master (
      output d_addr, d_wdata, d_wdata_oe, d_rd, d_wr,
      input  d_rdata, d_ack
   );

   modport slave (
      input  d_addr, d_wdata, d_wdata_oe, d_rd, d_wr,
      output d_rdata, d_ack
   );
endinterface

// File: rtl/zmips_dbus_ctrl.sv
// Data-bus controller: IDLE/WAIT FSM, wait counter, request latch and
// strobe generation. Reports done/abort/stall plus the selected
// address, register and write-enable for the MEM/WB register.
module zmips_dbus_ctrl
   import zmips_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_exAluRslt,
   input  logic [31:0] i_exStData,
   input  logic [4:0]  i_exWbReg,
   input  logic        i_exMemrd,
   input  logic        i_exMemwr,
   input  logic        i_exWrreg,
   zmips_dbus_if.master bus,
   output logic        o_done,
   output logic        o_abort,
   output logic        o_stall,
   output logic        o_misaligned,
   output logic [31:0] o_selAddr,
   output logic [4:0]  o_selReg,
   output logic        o_selWrreg,
   output logic        o_selLoad
);

   busState_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic             r_isStore;
   logic             r_isLoad;
   logic [4:0]       r_reg;
   logic             r_wrreg;

   logic        w_req;
   logic        w_mis;
   logic        w_go;
   logic        w_timeUp;
   logic [31:0] w_dAddr;
   logic [31:0] w_dWdata;
   logic        w_dOe;
   logic        w_dRd;
   logic        w_dWr;

   // A store wins over a load when both request bits are set.
   assign w_req    = i_exMemrd | i_exMemwr;
   assign w_mis    = w_req & isMisaligned(i_exAluRslt);
   assign w_go     = w_req & ~w_mis;
   assign w_timeUp = (r_cnt == CNT_W'(TIMEOUT));

   // Strobes and status: straight from ex_* in IDLE, from the latch in WAIT;
   // everything is forced quiet while reset is held.
   always_comb begin
      w_dAddr      = 32'd0;
      w_dWdata     = 32'd0;
      w_dOe        = 1'b0;
      w_dRd        = 1'b0;
      w_dWr        = 1'b0;
      o_done       = 1'b0;
      o_abort      = 1'b0;
      o_stall      = 1'b0;
      o_misaligned = 1'b0;
      o_selAddr    = i_exAluRslt;
      o_selReg     = i_exWbReg;
      o_selWrreg   = i_exWrreg;
      o_selLoad    = i_exMemrd & ~i_exMemwr;
      if (r_state == IDLE) begin
         o_misaligned = w_mis;
         if (w_go) begin
            w_dAddr = i_exAluRslt;
            w_dRd   = i_exMemrd & ~i_exMemwr;
            w_dWr   = i_exMemwr;
            if (i_exMemwr) begin
               w_dWdata = i_exStData;
               w_dOe    = 1'b1;
            end
            o_done  = bus.d_ack;
            o_stall = ~bus.d_ack;
         end
      end else begin
         o_selAddr  = r_addr;
         o_selReg   = r_reg;
         o_selWrreg = r_wrreg;
         o_selLoad  = r_isLoad;
         w_dAddr    = r_addr;
         w_dRd      = r_isLoad;
         w_dWr      = r_isStore;
         if (r_isStore) begin
            w_dWdata = r_wdata;
            w_dOe    = 1'b1;
         end
         o_done  = bus.d_ack;
         o_abort = ~bus.d_ack & w_timeUp;
         o_stall = ~bus.d_ack & ~w_timeUp;
      end
      if (rst) begin
         w_dAddr      = 32'd0;
         w_dWdata     = 32'd0;
         w_dOe        = 1'b0;
         w_dRd        = 1'b0;
         w_dWr        = 1'b0;
         o_done       = 1'b0;
         o_abort      = 1'b0;
         o_stall      = 1'b0;
         o_misaligned = 1'b0;
      end
   end

   assign bus.d_addr     = w_dAddr;
   assign bus.d_wdata    = w_dWdata;
   assign bus.d_wdata_oe = w_dOe;
   assign bus.d_rd       = w_dRd;
   assign bus.d_wr       = w_dWr;

   // FSM: latch an unacknowledged request, count wait cycles, leave WAIT on ack or timeout.
   always_ff @(negedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_addr    <= 32'd0;
         r_wdata   <= 32'd0;
         r_isStore <= 1'b0;
         r_isLoad  <= 1'b0;
         r_reg     <= REG_ZERO;
         r_wrreg   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_go && !bus.d_ack) begin
                  r_state   <= WAIT;
                  r_cnt     <= CNT_W'(1);
                  r_addr    <= i_exAluRslt;
                  r_wdata   <= i_exStData;
                  r_isStore <= i_exMemwr;
                  r_isLoad  <= i_exMemrd & ~i_exMemwr;
                  r_reg     <= i_exWbReg;
                  r_wrreg   <= i_exWrreg;
               end
            end
            WAIT: begin
               if (bus.d_ack || w_timeUp) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/zmips_mem_wb.sv
// zmips MEM stage top: data-bus controller plus the MEM/WB pipeline
// register and the sticky bus error flag.
module zmips_mem_wb
   import zmips_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ex_alu_rslt,
   input  logic [31:0] ex_st_data,
   input  logic [4:0]  ex_wb_reg,
   input  logic        ex_memrd,
   input  logic        ex_memwr,
   input  logic        ex_wrreg,
   zmips_dbus_if.master dbus,
   output logic        mem_stall,
   output logic        bus_err,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        wb_wr
);

   logic        w_done;
   logic        w_abort;
   logic        w_stall;
   logic        w_mis;
   logic [31:0] w_selAddr;
   logic [4:0]  w_selReg;
   logic        w_selWrreg;
   logic        w_selLoad;

   logic        r_busErr;
   logic [4:0]  r_wbAddr;
   logic [31:0] r_wbData;
   logic        r_wbWr;

   zmips_dbus_ctrl #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .i_exAluRslt  (ex_alu_rslt),
      .i_exStData   (ex_st_data),
      .i_exWbReg    (ex_wb_reg),
      .i_exMemrd    (ex_memrd),
      .i_exMemwr    (ex_memwr),
      .i_exWrreg    (ex_wrreg),
      .bus          (dbus),
      .o_done       (w_done),
      .o_abort      (w_abort),
      .o_stall      (w_stall),
      .o_misaligned (w_mis),
      .o_selAddr    (w_selAddr),
      .o_selReg     (w_selReg),
      .o_selWrreg   (w_selWrreg),
      .o_selLoad    (w_selLoad)
   );

   // MEM/WB register: bubble while stalled, otherwise capture the completed result.
   always_ff @(negedge clk) begin
      if (rst) begin
         r_busErr <= 1'b0;
         r_wbAddr <= REG_ZERO;
         r_wbData <= 32'd0;
         r_wbWr   <= 1'b0;
      end else begin
         if (w_abort || w_mis) begin
            r_busErr <= 1'b1;
         end
         if (w_stall) begin
            r_wbWr <= 1'b0;
         end else begin
            r_wbAddr <= w_selReg;
            r_wbData <= (w_selLoad && w_done) ? dbus.d_rdata : w_selAddr;
            r_wbWr   <= w_selWrreg & (w_selReg != REG_ZERO) & ~w_abort & ~w_mis;
         end
      end
   end

   assign mem_stall = w_stall;
   assign bus_err   = r_busErr;
   assign wb_addr   = r_wbAddr;
   assign wb_data   = r_wbData;
   assign wb_wr     = r_wbWr;

endmodule

// File: tb/tb_zmips_mem_wb.sv
// Scoreboard bench for zmips_mem_wb: each op pushes its expected MEM/WB
// result; a monitor pops and compares after every non-stalled update.
module tb_zmips_mem_wb;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      logic        wr;
      logic        err;
   } wbExp_t;

   logic        clk;
   logic        rst;
   logic [31:0] exAluRslt;
   logic [31:0] exStData;
   logic [4:0]  exWbReg;
   logic        exMemrd;
   logic        exMemwr;
   logic        exWrreg;
   logic        memStall;
   logic        busErr;
   logic [4:0]  wbAddr;
   logic [31:0] wbData;
   logic        wbWr;

   int          checks = 0;
   int          errors = 0;
   bit          monOn = 0;
   wbExp_t      sbQ[$];

   zmips_dbus_if dbus();

   zmips_mem_wb #(
      .TIMEOUT (4),
      .CNT_W   (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ex_alu_rslt (exAluRslt),
      .ex_st_data  (exStData),
      .ex_wb_reg   (exWbReg),
      .ex_memrd    (exMemrd),
      .ex_memwr    (exMemwr),
      .ex_wrreg    (exWrreg),
      .dbus        (dbus),
      .mem_stall   (memStall),
      .bus_err     (busErr),
      .wb_addr     (wbAddr),
      .wb_data     (wbData),
      .wb_wr       (wbWr)
   );

   // Free-running clock; state changes on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Issue one EX/MEM op at a rising edge and hold it until the DUT stops
   // stalling; ackWait is the cycle index on which d_ack rises (-1 = never).
   task automatic applyStimulus(
      input logic [31:0] alu, input logic [31:0] st, input logic [4:0] rg,
      input logic rd, input logic wr, input logic wrr,
      input int ackWait, input logic [31:0] rdata,
      input logic [4:0] eAddr, input logic [31:0] eData, input logic eWr, input logic eErr,
      input int eStrobe, input int eStall);
      int strobes = 0;
      int stalls  = 0;
      int bad     = 0;
      int cyc     = 0;
      logic s;
      exAluRslt = alu;
      exStData  = st;
      exWbReg   = rg;
      exMemrd   = rd;
      exMemwr   = wr;
      exWrreg   = wrr;
      sbQ.push_back('{eAddr, eData, eWr, eErr});
      do begin
         dbus.d_ack   = (cyc == ackWait);
         dbus.d_rdata = rdata;
         #2;
         if (dbus.d_rd || dbus.d_wr) begin
            strobes++;
            if (dbus.d_addr !== alu || dbus.d_rd !== (rd & ~wr) || dbus.d_wr !== wr ||
                dbus.d_wdata_oe !== wr || (wr && dbus.d_wdata !== st))
               bad++;
         end else if (dbus.d_wdata_oe !== 1'b0) begin
            bad++;
         end
         s = memStall;
         if (s) stalls++;
         @(posedge clk);
         cyc++;
      end while (s && cyc < 64);
      dbus.d_ack = 1'b0;
      checkOutput("strobe_fields", bad, 0);
      checkOutput("strobe_cycles", strobes, eStrobe);
      checkOutput("stall_cycles", stalls, eStall);
   endtask

   // Monitor: every non-stalled, non-reset falling edge is a MEM/WB update to check.
   initial begin
      bit upd;
      wbExp_t e;
      forever begin
         @(posedge clk);
         #4;
         upd = !rst && !memStall && monOn;
         @(negedge clk);
         #1;
         if (upd) begin
            if (sbQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_wb: got update wb_addr=%0d with no expected entry", wbAddr);
            end else begin
               e = sbQ.pop_front();
               checkOutput("wb_addr", wbAddr, e.addr);
               checkOutput("wb_data", wbData, e.data);
               checkOutput("wb_wr", wbWr, e.wr);
               checkOutput("bus_err", busErr, e.err);
            end
         end
      end
   end

   // Directed sequence with hand-computed results (TIMEOUT = 4).
   initial begin
      rst = 1'b1;
      exAluRslt = 0; exStData = 0; exWbReg = 0;
      exMemrd = 0; exMemwr = 0; exWrreg = 0;
      dbus.d_ack = 1'b0;
      dbus.d_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_wb_wr", wbWr, 0);
      checkOutput("rst_wb_data", wbData, 0);
      checkOutput("rst_bus_err", busErr, 0);
      checkOutput("rst_d_rd", dbus.d_rd, 0);
      checkOutput("rst_stall", memStall, 0);
      @(posedge clk);
      rst = 1'b0;
      monOn = 1'b1;

      applyStimulus(32'h1234, 0, 5, 0, 0, 1, -1, 0, 5, 32'h1234, 1, 0, 0, 0);
      applyStimulus(32'h100, 0, 3, 1, 0, 1, 0, 32'hCAFEF00D, 3, 32'hCAFEF00D, 1, 0, 1, 0);
      applyStimulus(32'h200, 32'hA5A5A5A5, 0, 0, 1, 0, 3, 0, 0, 32'h200, 0, 0, 4, 3);
      applyStimulus(32'h208, 32'hDEAD, 10, 1, 1, 1, 0, 32'hFFFFFFFF, 10, 32'h208, 1, 0, 1, 0);
      applyStimulus(32'h300, 0, 7, 1, 0, 1, -1, 32'h0BADBEEF, 7, 32'h300, 0, 1, 5, 4);
      applyStimulus(32'h104, 0, 8, 1, 0, 1, 1, 32'h11112222, 8, 32'h11112222, 1, 1, 2, 1);
      applyStimulus(32'h102, 0, 9, 1, 0, 1, 0, 32'h33334444, 9, 32'h102, 0, 1, 0, 0);
      applyStimulus(32'h55, 0, 0, 0, 0, 1, -1, 0, 0, 32'h55, 0, 1, 0, 0);

      monOn = 1'b0;
      // Reset arriving in the second WAIT cycle of a load.
      exAluRslt = 32'h400; exWbReg = 4; exMemrd = 1; exMemwr = 0; exWrreg = 1;
      dbus.d_ack = 1'b0;
      repeat (2) @(posedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("wait_rst_d_rd", dbus.d_rd, 0);
      checkOutput("wait_rst_stall", memStall, 0);
      checkOutput("wait_rst_wb_wr", wbWr, 0);
      checkOutput("wait_rst_bus_err", busErr, 0);
      @(posedge clk);
      exMemrd = 0; exWrreg = 0;
      rst = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("post_rst_d_rd", dbus.d_rd, 0);
      checkOutput("scoreboard_empty", sbQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
